seven_seg_scan_ctrl: RTL and testbench

Scan controller for the four-digit multiplexed seven-segment display. It time-multiplexes the shared segment decoder across the four operand/result digits (A, B, A+B, A−B). It generates the active-low anode strobes that feed both the decoder's digit select and the display pins. Operand values and digit-enable mask are frame-latched, so a digit never changes mid-frame and the display never tears.

---
 rtl/seven_seg_pkg.sv | 13 +
 rtl/seven_seg_scan_ctrl_tick.sv | 36 +++
 rtl/seven_seg_scan_ctrl.sv | 154 +++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan controller.
package seven_seg_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      ON    = 2'd2
   } scan_state_t;

   localparam logic [3:0] ANODE_OFF  = 4'b1111;
   localparam int         NUM_DIGITS = 4;

endpackage

// File: rtl/seven_seg_scan_ctrl_tick.sv
// scan_tick_counter: counts 0..N-1 while enabled and flags the terminal count.
module scan_tick_counter #(
   parameter int N = 1,
   parameter int W = $clog2(N) + 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic done
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   assign done = (cnt_q == W'(N - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = done ? '0 : cnt_q + W'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit seven-segment scan controller with frame-latched values and active-low anodes.
// Define SEVEN_SEG_BLANK_EN to insert an all-dark BLANK period before each digit.
module seven_seg_scan_ctrl
   import seven_seg_pkg::*;
#(
   parameter int DIGIT_TICKS = 100000,
   parameter int BLANK_TICKS = 1000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [NUM_DIGITS-1:0] digit_en,
   input  logic [3:0]            A,
   input  logic [3:0]            B,
   input  logic [3:0]            AplusB,
   input  logic [3:0]            AminusB,
   output logic [3:0]            A_q,
   output logic [3:0]            B_q,
   output logic [3:0]            AplusB_q,
   output logic [3:0]            AminusB_q,
   output logic [NUM_DIGITS-1:0] anode,
   output logic [1:0]            digit_idx,
   output logic                  frame_start
);

   localparam int MAX_TICKS = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
   localparam int CNT_W     = $clog2(MAX_TICKS) + 1;

`ifdef SEVEN_SEG_BLANK_EN
   localparam scan_state_t SLOT_ENTRY = BLANK;
`else
   localparam scan_state_t SLOT_ENTRY = ON;
`endif

   scan_state_t           state_q, state_d;
   logic [1:0]            digit_idx_q, digit_idx_d;
   logic [NUM_DIGITS-1:0] anode_q, anode_d;
   logic                  frame_start_q, frame_start_d;
   logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;
   logic [3:0]            A_d, B_d, AplusB_d, AminusB_d;
   logic                  latch;
   logic                  dig_run, dig_done;

   assign dig_run = en && (state_q == ON);

   scan_tick_counter #(.N(DIGIT_TICKS), .W(CNT_W)) u_digit_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (!dig_run),
      .en   (dig_run),
      .done (dig_done)
   );

`ifdef SEVEN_SEG_BLANK_EN
   logic blk_run, blk_done;

   assign blk_run = en && (state_q == BLANK);

   scan_tick_counter #(.N(BLANK_TICKS), .W(CNT_W)) u_blank_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (!blk_run),
      .en   (blk_run),
      .done (blk_done)
   );
`endif

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d       = state_q;
      digit_idx_d   = digit_idx_q;
      frame_start_d = 1'b0;
      latch         = 1'b0;

      if (!en) begin
         state_d     = IDLE;
         digit_idx_d = 2'd0;
      end else begin
         case (state_q)
            IDLE: begin
               latch       = 1'b1;
               digit_idx_d = 2'd0;
               state_d     = SLOT_ENTRY;
            end
`ifdef SEVEN_SEG_BLANK_EN
            BLANK: begin
               if (blk_done) state_d = ON;
            end
`endif
            ON: begin
               if (dig_done) begin
                  state_d = SLOT_ENTRY;
                  if (digit_idx_q == 2'd3) begin
                     digit_idx_d = 2'd0;
                     latch       = 1'b1;
                  end else begin
                     digit_idx_d = digit_idx_q + 2'd1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end

      A_d        = A_q;
      B_d        = B_q;
      AplusB_d   = AplusB_q;
      AminusB_d  = AminusB_q;
      digit_en_d = digit_en_q;
      if (latch) begin
         A_d           = A;
         B_d           = B;
         AplusB_d      = AplusB;
         AminusB_d     = AminusB;
         digit_en_d    = digit_en;
         frame_start_d = 1'b1;
      end

      // Anode is derived from next-cycle state and mask so it registers in step with them.
      anode_d = ANODE_OFF;
      if (state_d == ON && digit_en_d[digit_idx_d]) begin
         anode_d[digit_idx_d] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         digit_idx_q   <= 2'd0;
         anode_q       <= ANODE_OFF;
         frame_start_q <= 1'b0;
         digit_en_q    <= '0;
         A_q           <= '0;
         B_q           <= '0;
         AplusB_q      <= '0;
         AminusB_q     <= '0;
      end else begin
         state_q       <= state_d;
         digit_idx_q   <= digit_idx_d;
         anode_q       <= anode_d;
         frame_start_q <= frame_start_d;
         digit_en_q    <= digit_en_d;
         A_q           <= A_d;
         B_q           <= B_d;
         AplusB_q      <= AplusB_d;
         AminusB_q     <= AminusB_d;
      end
   end

   assign anode       = anode_q;
   assign digit_idx   = digit_idx_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench for seven_seg_scan_ctrl: stimulus queues expected per-cycle outputs, a monitor compares.
module tb_seven_seg_scan_ctrl;

   localparam int DT = 4;
   localparam int BT = 2;
`ifdef SEVEN_SEG_BLANK_EN
   localparam int BLANK_CYC = BT;
`else
   localparam int BLANK_CYC = 0;
`endif

   logic       clk;
   logic       rst;
   logic       en;
   logic [3:0] digit_en;
   logic [3:0] A, B, AplusB, AminusB;
   logic [3:0] A_q, B_q, AplusB_q, AminusB_q;
   logic [3:0] anode;
   logic [1:0] digit_idx;
   logic       frame_start;

   seven_seg_scan_ctrl #(.DIGIT_TICKS(DT), .BLANK_TICKS(BT)) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .digit_en    (digit_en),
      .A           (A),
      .B           (B),
      .AplusB      (AplusB),
      .AminusB     (AminusB),
      .A_q         (A_q),
      .B_q         (B_q),
      .AplusB_q    (AplusB_q),
      .AminusB_q   (AminusB_q),
      .anode       (anode),
      .digit_idx   (digit_idx),
      .frame_start (frame_start)
   );

   typedef struct packed {
      logic [3:0] anode;
      logic [1:0] idx;
      logic       fs;
      logic [3:0] a, b, apb, amb;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   tests_run    = 0;
   int   tests_failed = 0;
   int   cycle_no     = 0;

   // Values the shadow registers are expected to hold for the frame being queued.
   logic [3:0] cur_a, cur_b, cur_apb, cur_amb;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests_run++;
      if (act !== req) begin
         tests_failed++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cycle_no, act, req);
      end
   endtask

   // Queue the output expected after the next rising edge, then move to the following negedge.
   task automatic step(input logic [3:0] an, input logic [1:0] idx, input logic fs);
      exp_t e;
      e.anode = an;
      e.idx   = idx;
      e.fs    = fs;
      e.a     = cur_a;
      e.b     = cur_b;
      e.apb   = cur_apb;
      e.amb   = cur_amb;
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   task automatic slot(input int d, input logic [3:0] mask, input int on_cycles, input bit first);
      logic [3:0] lit;
      lit    = 4'b1111;
      lit[d] = 1'b0;
      for (int i = 0; i < BLANK_CYC; i++) step(4'b1111, d[1:0], first && (i == 0));
      for (int i = 0; i < on_cycles; i++)
         step(mask[d] ? lit : 4'b1111, d[1:0], first && (BLANK_CYC == 0) && (i == 0));
   endtask

   task automatic frame(input logic [3:0] mask);
      for (int d = 0; d < 4; d++) slot(d, mask, DT, d == 0);
   endtask

   always @(posedge clk) begin
      #1;
      cycle_no++;
      if (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         check("anode",       32'(anode),       32'(mon_e.anode));
         check("digit_idx",   32'(digit_idx),   32'(mon_e.idx));
         check("frame_start", 32'(frame_start), 32'(mon_e.fs));
         check("A_q",         32'(A_q),         32'(mon_e.a));
         check("B_q",         32'(B_q),         32'(mon_e.b));
         check("AplusB_q",    32'(AplusB_q),    32'(mon_e.apb));
         check("AminusB_q",   32'(AminusB_q),   32'(mon_e.amb));
      end
   end

   initial begin
      rst = 1'b1; en = 1'b1; digit_en = 4'b1111;
      A = 4'd3; B = 4'd5; AplusB = 4'd8; AminusB = 4'd14;
      cur_a = 4'd0; cur_b = 4'd0; cur_apb = 4'd0; cur_amb = 4'd0;
      @(negedge clk);

      // Reset held with en high: display dark, shadows zero.
      repeat (3) step(4'b1111, 2'd0, 1'b0);

      // Frame 1: A changes during the B slot but must not show until the next latch.
      rst = 1'b0;
      cur_a = 4'd3; cur_b = 4'd5; cur_apb = 4'd8; cur_amb = 4'd14;
      slot(0, 4'b1111, DT, 1'b1);
      A = 4'd9;
      for (int d = 1; d < 4; d++) slot(d, 4'b1111, DT, 1'b0);

      // Frame 2 shows A=9; a new mask is presented mid-frame.
      cur_a = 4'd9;
      slot(0, 4'b1111, DT, 1'b1);
      slot(1, 4'b1111, DT, 1'b0);
      digit_en = 4'b0101;
      slot(2, 4'b1111, DT, 1'b0);
      slot(3, 4'b1111, DT, 1'b0);

      // Frame 3 uses mask 0101: B and AminusB slots stay dark with unchanged timing.
      slot(0, 4'b0101, DT, 1'b1);
      digit_en = 4'b1111;
      for (int d = 1; d < 4; d++) slot(d, 4'b0101, DT, 1'b0);

      // Frame 4: drop en partway through the AplusB ON slot.
      slot(0, 4'b1111, DT, 1'b1);
      slot(1, 4'b1111, DT, 1'b0);
      slot(2, 4'b1111, 2, 1'b0);
      en = 1'b0;
      step(4'b1111, 2'd0, 1'b0);
      step(4'b1111, 2'd0, 1'b0);

      // Re-enable with new A: restart at digit 0 with a frame_start pulse, then one more frame.
      en = 1'b1;
      A  = 4'd7;
      cur_a = 4'd7;
      frame(4'b1111);
      frame(4'b1111);

      repeat (2) @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
